uart_transceiver: RTL and testbench

Parametrised full-duplex UART transceiver. It is the next generation of the fixed 8-bit TX/RX pair. It adds configurable data width, parity mode and stop-bit count, a 16x oversampling baud generator, valid/ready handshakes on both byte interfaces, framing/overrun detection and a runtime internal-loopback mode. It sits between the system bus logic and the serial pins.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_transceiver.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity modes and baud divisor helper
// Shared definitions for the UART transceiver and its baud generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Clocks per 16x oversampling tick, rounded to nearest.
  function automatic int calc_div(input int clk_rate, input int br);
    return (clk_rate + br * 8) / (br * 16);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - 16x oversampling tick generator
// Emits a one-cycle tick every DIV clocks; sync_clr realigns the phase so
// a tick lands exactly DIV clocks after the clear.
module uart_baud_gen #(
  parameter int CLK_RATE = 50_000_000,
  parameter int BR       = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_clr,
  output logic tick
);
  import uart_pkg::*;

  localparam int DIV = calc_div(CLK_RATE, BR);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Free-running modulo-DIV counter, optionally realigned by sync_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (sync_clr || cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - parametrised full-duplex UART with loopback
// TX and RX state machines with valid/ready byte interfaces, parity,
// framing and overrun reporting, and an internal loopback path.
module uart_transceiver #(
  parameter int BR        = 9600,
  parameter int CLK_RATE  = 50_000_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_active,
  output logic                 serial_out,
  input  logic                 serial_in,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun
);
  import uart_pkg::*;

  localparam int   DIV     = calc_div(CLK_RATE, BR);
  localparam int   BCW     = $clog2(DATA_BITS + 1);
  localparam logic ODD     = (PARITY == PAR_ODD);
  localparam bit   HAS_PAR = (PARITY != PAR_NONE);

  if (DIV < 1) begin : g_bad_div
    $error("uart_transceiver: baud divisor below 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_transceiver: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_transceiver: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_transceiver: STOP_BITS must be 1 or 2");
  end

  // TX uses its own realigned tick so each bit is exactly 16*DIV clocks;
  // RX oversamples from a free-running tick.
  logic tick_tx;
  logic tick_rx;
  logic tx_start;

  assign tx_start = tx_valid & tx_ready;

  uart_baud_gen #(.CLK_RATE(CLK_RATE), .BR(BR)) u_baud_tx (
    .clk      (clk),
    .reset    (reset),
    .sync_clr (tx_start),
    .tick     (tick_tx)
  );

  uart_baud_gen #(.CLK_RATE(CLK_RATE), .BR(BR)) u_baud_rx (
    .clk      (clk),
    .reset    (reset),
    .sync_clr (1'b0),
    .tick     (tick_rx)
  );

  uart_state_t          tx_state;
  logic [3:0]           tx_phase;
  logic [BCW-1:0]       tx_bitcnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par_bit;
  logic                 serial_out_int;

  // TX FSM: start, LSB-first data, optional parity, stop bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state       <= IDLE;
      tx_phase       <= '0;
      tx_bitcnt      <= '0;
      tx_shift       <= '0;
      tx_par_bit     <= 1'b0;
      serial_out_int <= 1'b1;
      tx_ready       <= 1'b1;
      tx_active      <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_start) begin
            tx_shift       <= tx_data;
            tx_par_bit     <= ^tx_data ^ ODD;
            tx_phase       <= '0;
            tx_bitcnt      <= '0;
            serial_out_int <= 1'b0;
            tx_ready       <= 1'b0;
            tx_active      <= 1'b1;
            tx_state       <= START;
          end
        end
        default: begin
          if (tick_tx) begin
            tx_phase <= tx_phase + 4'd1;
            if (tx_phase == 4'd15) begin
              case (tx_state)
                START: begin
                  serial_out_int <= tx_shift[0];
                  tx_shift       <= tx_shift >> 1;
                  tx_bitcnt      <= '0;
                  tx_state       <= DATA;
                end
                DATA: begin
                  if (tx_bitcnt == BCW'(DATA_BITS - 1)) begin
                    tx_bitcnt <= '0;
                    if (HAS_PAR) begin
                      serial_out_int <= tx_par_bit;
                      tx_state       <= uart_pkg::PARITY;
                    end else begin
                      serial_out_int <= 1'b1;
                      tx_state       <= STOP;
                    end
                  end else begin
                    serial_out_int <= tx_shift[0];
                    tx_shift       <= tx_shift >> 1;
                    tx_bitcnt      <= tx_bitcnt + 1'b1;
                  end
                end
                uart_pkg::PARITY: begin
                  serial_out_int <= 1'b1;
                  tx_bitcnt      <= '0;
                  tx_state       <= STOP;
                end
                STOP: begin
                  if (tx_bitcnt == BCW'(STOP_BITS - 1)) begin
                    tx_ready  <= 1'b1;
                    tx_active <= 1'b0;
                    tx_state  <= IDLE;
                  end else begin
                    tx_bitcnt <= tx_bitcnt + 1'b1;
                  end
                end
                default: tx_state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign serial_out = loopback ? 1'b1 : serial_out_int;

  logic rx_line;
  logic rx_sync1;
  logic rx_sync2;
  logic rx_prev;
  logic rx_fall;

  assign rx_line = loopback ? serial_out_int : serial_in;
  assign rx_fall = rx_prev & ~rx_sync2;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= rx_line;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  uart_state_t          rx_state;
  logic [3:0]           rx_phase;
  logic [BCW-1:0]       rx_bitcnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;

  // RX FSM with output handshake; a completed frame load overrides a consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state     <= IDLE;
      rx_phase     <= '0;
      rx_bitcnt    <= '0;
      rx_shift     <= '0;
      rx_par_bit   <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid     <= 1'b0;
        parity_error <= 1'b0;
        frame_error  <= 1'b0;
      end
      case (rx_state)
        IDLE: begin
          if (rx_fall) begin
            rx_phase <= '0;
            rx_state <= START;
          end
        end
        default: begin
          if (tick_rx) begin
            rx_phase <= rx_phase + 4'd1;
            case (rx_state)
              START: begin
                if (rx_phase == 4'd7) begin
                  rx_phase  <= '0;
                  rx_bitcnt <= '0;
                  rx_state  <= rx_sync2 ? IDLE : DATA;
                end
              end
              DATA: begin
                if (rx_phase == 4'd15) begin
                  rx_shift <= {rx_sync2, rx_shift[DATA_BITS-1:1]};
                  if (rx_bitcnt == BCW'(DATA_BITS - 1)) begin
                    rx_state <= HAS_PAR ? uart_pkg::PARITY : STOP;
                  end else begin
                    rx_bitcnt <= rx_bitcnt + 1'b1;
                  end
                end
              end
              uart_pkg::PARITY: begin
                if (rx_phase == 4'd15) begin
                  rx_par_bit <= rx_sync2;
                  rx_state   <= STOP;
                end
              end
              STOP: begin
                if (rx_phase == 4'd15) begin
                  rx_data      <= rx_shift;
                  parity_error <= HAS_PAR && ((^rx_shift ^ ODD) != rx_par_bit);
                  frame_error  <= ~rx_sync2;
                  rx_valid     <= 1'b1;
                  overrun      <= rx_valid & ~rx_ready;
                  rx_state     <= IDLE;
                end
              end
              default: rx_state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed self-checking bench for uart_transceiver
module tb_uart_transceiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks = 0;
  int   errors = 0;

  // DUT A: 8N1
  logic [7:0] a_tx_data;
  logic       a_tx_valid, a_tx_ready, a_tx_active, a_serial_out, a_serial_in, a_loopback;
  logic [7:0] a_rx_data;
  logic       a_rx_valid, a_rx_ready, a_perr, a_ferr, a_ovr;

  // DUT B: 8 data, odd parity, 1 stop
  logic [7:0] b_tx_data;
  logic       b_tx_valid, b_tx_ready, b_tx_active, b_serial_out, b_serial_in, b_loopback;
  logic [7:0] b_rx_data;
  logic       b_rx_valid, b_rx_ready, b_perr, b_ferr, b_ovr;

  // DUT C: 9 data, no parity, 2 stop
  logic [8:0] c_tx_data;
  logic       c_tx_valid, c_tx_ready, c_tx_active, c_serial_out, c_serial_in, c_loopback;
  logic [8:0] c_rx_data;
  logic       c_rx_valid, c_rx_ready, c_perr, c_ferr, c_ovr;

  uart_transceiver #(.BR(10_000), .CLK_RATE(1_600_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx_active(a_tx_active), .serial_out(a_serial_out), .serial_in(a_serial_in), .loopback(a_loopback),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .parity_error(a_perr),
    .frame_error(a_ferr), .overrun(a_ovr)
  );

  uart_transceiver #(.BR(10_000), .CLK_RATE(1_600_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx_active(b_tx_active), .serial_out(b_serial_out), .serial_in(b_serial_in), .loopback(b_loopback),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .parity_error(b_perr),
    .frame_error(b_ferr), .overrun(b_ovr)
  );

  uart_transceiver #(.BR(10_000), .CLK_RATE(1_600_000), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .reset(reset), .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .tx_active(c_tx_active), .serial_out(c_serial_out), .serial_in(c_serial_in), .loopback(c_loopback),
    .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready), .parity_error(c_perr),
    .frame_error(c_ferr), .overrun(c_ovr)
  );

  int a_ovr_cnt = 0;
  always @(posedge clk) if (a_ovr === 1'b1) a_ovr_cnt <= a_ovr_cnt + 1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic a_send(input logic [7:0] d);
    int t = 0;
    while (a_tx_ready !== 1'b1 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk1("a_send_ready", a_tx_ready, 1'b1);
    a_tx_data  = d;
    a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
  endtask

  task automatic a_wait_rx(output int n);
    n = 1;
    while (a_rx_valid !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk1("a_rx_valid_seen", a_rx_valid, 1'b1);
  endtask

  task automatic a_consume();
    a_rx_ready = 1'b1;
    @(negedge clk);
    a_rx_ready = 1'b0;
    chk1("a_rx_valid_cleared", a_rx_valid, 1'b0);
  endtask

  task automatic a_frame(input logic [7:0] d, input logic stop_v);
    a_serial_in = 1'b0;
    cyc(160);
    for (int i = 0; i < 8; i++) begin
      a_serial_in = d[i];
      cyc(160);
    end
    a_serial_in = stop_v;
    cyc(160);
    a_serial_in = 1'b1;
    cyc(20);
  endtask

  task automatic b_frame(input logic [7:0] d, input logic par);
    b_serial_in = 1'b0;
    cyc(160);
    for (int i = 0; i < 8; i++) begin
      b_serial_in = d[i];
      cyc(160);
    end
    b_serial_in = par;
    cyc(160);
    b_serial_in = 1'b1;
    cyc(160);
  endtask

  initial begin
    int n;
    int base;
    int lo;
    int hi;
    logic line_bad;
    logic busy_bad;

    reset = 1'b0;
    a_tx_data = '0; a_tx_valid = 0; a_serial_in = 1; a_loopback = 0; a_rx_ready = 0;
    b_tx_data = '0; b_tx_valid = 0; b_serial_in = 1; b_loopback = 0; b_rx_ready = 0;
    c_tx_data = '0; c_tx_valid = 0; c_serial_in = 1; c_loopback = 0; c_rx_ready = 0;
    cyc(3);

    chk1("rst_serial_out", a_serial_out, 1'b1);
    chk1("rst_tx_ready", a_tx_ready, 1'b1);
    chk1("rst_tx_active", a_tx_active, 1'b0);
    chk1("rst_rx_valid", a_rx_valid, 1'b0);
    chkv("rst_rx_data", 32'(a_rx_data), 32'h0);
    chk1("rst_parity_error", a_perr, 1'b0);
    chk1("rst_frame_error", a_ferr, 1'b0);
    chk1("rst_overrun", a_ovr, 1'b0);
    chk1("rst_c_tx_ready", c_tx_ready, 1'b1);

    reset = 1'b1;
    cyc(5);

    // Loopback 0xA5: line stays high, byte arrives about 1520 clocks later.
    a_loopback = 1'b1;
    a_send(8'hA5);
    chk1("lb_tx_ready_low", a_tx_ready, 1'b0);
    chk1("lb_tx_active", a_tx_active, 1'b1);
    line_bad = 1'b0;
    n = 1;
    while (a_rx_valid !== 1'b1 && n < 4000) begin
      if (a_serial_out !== 1'b1) line_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk1("lb_serial_out_high", line_bad, 1'b0);
    chk1("lb_rx_valid", a_rx_valid, 1'b1);
    chk1("lb_latency_window", (n >= 1500 && n <= 1540), 1'b1);
    chkv("lb_rx_data", 32'(a_rx_data), 32'hA5);
    chk1("lb_parity_error", a_perr, 1'b0);
    chk1("lb_frame_error", a_ferr, 1'b0);
    a_consume();

    // Overrun: two bytes without consuming.
    base = a_ovr_cnt;
    a_send(8'h11);
    a_wait_rx(n);
    chkv("ovr_first_data", 32'(a_rx_data), 32'h11);
    cyc(2);
    chkv("ovr_none_yet", 32'(a_ovr_cnt - base), 32'd0);
    a_send(8'h22);
    n = 0;
    while (a_rx_data !== 8'h22 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    cyc(2);
    chkv("ovr_second_data", 32'(a_rx_data), 32'h22);
    chk1("ovr_rx_valid_kept", a_rx_valid, 1'b1);
    chkv("ovr_pulse_count", 32'(a_ovr_cnt - base), 32'd1);
    a_consume();

    // External frame 0x55 with a low stop bit.
    a_loopback = 1'b0;
    cyc(200);
    a_frame(8'h55, 1'b0);
    chk1("fe_rx_valid", a_rx_valid, 1'b1);
    chkv("fe_rx_data", 32'(a_rx_data), 32'h55);
    chk1("fe_frame_error", a_ferr, 1'b1);
    chk1("fe_parity_error", a_perr, 1'b0);
    a_consume();
    chk1("fe_flag_cleared", a_ferr, 1'b0);

    // 40-clock glitch must not produce a byte.
    a_serial_in = 1'b0;
    cyc(40);
    a_serial_in = 1'b1;
    cyc(400);
    chk1("glitch_no_rx", a_rx_valid, 1'b0);

    // Odd parity: 0x3C has four ones, so the correct parity bit is 1.
    b_frame(8'h3C, 1'b0);
    chk1("par_bad_valid", b_rx_valid, 1'b1);
    chkv("par_bad_data", 32'(b_rx_data), 32'h3C);
    chk1("par_bad_perr", b_perr, 1'b1);
    chk1("par_bad_ferr", b_ferr, 1'b0);
    b_rx_ready = 1'b1;
    @(negedge clk);
    b_rx_ready = 1'b0;
    chk1("par_consumed", b_rx_valid, 1'b0);
    b_frame(8'h3C, 1'b1);
    chk1("par_ok_valid", b_rx_valid, 1'b1);
    chkv("par_ok_data", 32'(b_rx_data), 32'h3C);
    chk1("par_ok_perr", b_perr, 1'b0);

    // 9 data bits, 2 stop bits: exact bit timing, busy-time tx_valid ignored.
    c_tx_data  = 9'h1FF;
    c_tx_valid = 1'b1;
    @(negedge clk);
    c_tx_valid = 1'b0;
    busy_bad = 1'b0;
    lo = 0;
    while (c_serial_out === 1'b0 && lo < 400) begin
      if (c_tx_ready !== 1'b0) busy_bad = 1'b1;
      lo++;
      @(negedge clk);
    end
    hi = 0;
    while (c_serial_out === 1'b1 && c_tx_ready === 1'b0 && hi < 4000) begin
      hi++;
      if (hi == 100 || hi == 900) begin
        c_tx_data  = 9'h000;
        c_tx_valid = 1'b1;
      end else begin
        c_tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    c_tx_valid = 1'b0;
    chkv("c_start_len", 32'(lo), 32'd160);
    chkv("c_high_len", 32'(hi), 32'd1760);
    chk1("c_busy_ready_low", busy_bad, 1'b0);
    chk1("c_tx_ready_back", c_tx_ready, 1'b1);
    cyc(300);
    chk1("c_no_queue_active", c_tx_active, 1'b0);
    chk1("c_no_queue_line", c_serial_out, 1'b1);

    // Reset in the middle of a data bit.
    a_loopback = 1'b1;
    a_send(8'h33);
    a_wait_rx(n);
    n = 0;
    while (a_tx_ready !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    a_loopback = 1'b0;
    a_send(8'h00);
    cyc(399);
    chk1("mid_line_low", a_serial_out, 1'b0);
    chk1("mid_rx_valid_pending", a_rx_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("mid_rst_serial_out", a_serial_out, 1'b1);
    chk1("mid_rst_tx_ready", a_tx_ready, 1'b1);
    chk1("mid_rst_tx_active", a_tx_active, 1'b0);
    chk1("mid_rst_rx_valid", a_rx_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cyc(5);

    a_loopback = 1'b1;
    a_send(8'h0F);
    a_wait_rx(n);
    chkv("post_rst_data", 32'(a_rx_data), 32'h0F);
    chk1("post_rst_latency_window", (n >= 1500 && n <= 1540), 1'b1);
    chk1("post_rst_perr", a_perr, 1'b0);
    chk1("post_rst_ferr", a_ferr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
